// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and helpers for the arb_mux_n merge block.
//   ARB_RR / ARB_FIXED : arbitration mode encodings for the ARB_MODE parameter
//   occ_state_e        : occupancy of the one-entry output register
//   sel_width(n)       : grant-index width, max(1, clog2(n))
package arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    OCC_EMPTY = 1'b0,
    OCC_FULL  = 1'b1
  } occ_state_e;

  // A single channel still needs a 1-bit index so out_sel is never zero-width.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// arb_mux_n_if: producer/consumer handshake bundle for arb_mux_n.
//   in_valid  [CHANNELS]            per-channel request valid
//   in_data   [CHANNELS*DATA_WIDTH] flattened payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready  [CHANNELS]            per-channel accept, at most one bit high
//   out_valid / out_data / out_sel  registered output entry and its source channel
//   out_ready                       consumer accepts the output entry
// Modports: master = producers plus consumer (environment), slave = the mux.
interface arb_mux_n_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4
) ();
  import arb_pkg::*;

  localparam int SEL_WIDTH = sel_width(CHANNELS);

  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_ready;
  logic                           out_valid;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [SEL_WIDTH-1:0]           out_sel;
  logic                           out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/arb_mux_n_rr_arbiter.sv
// rr_arbiter: purely combinational request arbiter.
//   req       : request vector, one bit per channel
//   ptr       : round-robin start channel (ignored in fixed-priority mode)
//   mode      : 0 = round-robin from ptr, 1 = fixed priority (lowest index wins)
//   grant     : one-hot grant, all zero when no request
//   grant_idx : index of the granted channel (0 when none)
//   grant_any : some channel is granted
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0]  req,
  input  logic [SEL_WIDTH-1:0] ptr,
  input  logic                 mode,
  output logic [CHANNELS-1:0]  grant,
  output logic [SEL_WIDTH-1:0] grant_idx,
  output logic                 grant_any
);

  int start;
  int idx;

  // Scan every channel once starting at 'start', wrapping explicitly so a
  // non-power-of-two channel count never indexes past the last channel.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise a path that skips the assignment would infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    start     = mode ? 0 : int'(ptr);
    if (start >= CHANNELS) start = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = start + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-input registered handshake multiplexer.
//   clk  : single clock, all state updates on its rising edge
//   rst  : synchronous, active-high reset
//   bus  : arb_mux_n_if slave modport (in_valid/in_data/in_ready from the
//          producers, out_valid/out_data/out_sel/out_ready to the consumer)
// One arbitrated channel is loaded into a one-entry output register per
// cycle; a full register that is drained in the same cycle is refilled on
// that edge, giving one transfer per cycle under sustained traffic.
module arb_mux_n
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int ARB_MODE   = ARB_RR
) (
  input logic         clk,
  input logic         rst,
  arb_mux_n_if.slave  bus
);

  localparam int   SEL_WIDTH  = sel_width(CHANNELS);
  localparam logic FIXED_MODE = (ARB_MODE == ARB_FIXED);

  occ_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;

  logic [CHANNELS-1:0]   grant;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [SEL_WIDTH-1:0]  ptr_next;
  logic                  can_load;
  logic                  load;

  rr_arbiter #(
    .CHANNELS  (CHANNELS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .mode      (FIXED_MODE),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The register can take a new entry when empty or when it drains this cycle.
  assign can_load = (state_q == OCC_EMPTY) || bus.out_ready;
  assign load     = can_load && grant_any && !rst;

  // Grant is one-hot, so the request that is granted is also the one that
  // transfers; in_ready is forced low through the whole reset cycle.
  assign bus.in_ready = grant & {CHANNELS{can_load && !rst}};

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) grant_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Explicit wrap keeps the pointer inside 0..CHANNELS-1 for any channel count.
  assign ptr_next = (grant_idx == SEL_WIDTH'(CHANNELS - 1)) ? '0
                                                            : grant_idx + SEL_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = OCC_FULL;
      data_d  = grant_data;
      sel_d   = grant_idx;
      ptr_d   = ptr_next;
    end else if (bus.out_ready) begin
      // Drain with nothing to refill; payload and index keep their last value.
      state_d = OCC_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= OCC_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == OCC_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: self-checking bench for arb_mux_n.
// Three instances: id 0 = 4 channels round-robin, id 1 = 4 channels fixed
// priority, id 2 = 3 channels round-robin. A transaction-level model of the
// output register and pointer predicts in_ready and the registered outputs.
module tb_arb_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  arb_mux_n_if #(.DATA_WIDTH(32), .CHANNELS(4)) b4 ();
  arb_mux_n_if #(.DATA_WIDTH(32), .CHANNELS(4)) f4 ();
  arb_mux_n_if #(.DATA_WIDTH(32), .CHANNELS(3)) b3 ();

  arb_mux_n #(.DATA_WIDTH(32), .CHANNELS(4), .ARB_MODE(0)) u_rr4 (
    .clk (clk), .rst (rst0), .bus (b4.slave));
  arb_mux_n #(.DATA_WIDTH(32), .CHANNELS(4), .ARB_MODE(1)) u_fx4 (
    .clk (clk), .rst (rst1), .bus (f4.slave));
  arb_mux_n #(.DATA_WIDTH(32), .CHANNELS(3), .ARB_MODE(0)) u_rr3 (
    .clk (clk), .rst (rst2), .bus (b3.slave));

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-instance configuration and model state.
  int          n_ch [3] = '{4, 4, 3};
  int          mode [3] = '{0, 1, 0};
  logic [31:0] ch_data [3][16];
  logic [15:0] cur_v   [3];
  logic        cur_r   [3];
  logic        cur_rst [3];
  logic        m_full  [3];
  logic [31:0] m_data  [3];
  int          m_sel   [3];
  int          m_ptr   [3];

  logic [15:0] rdy;
  logic [36:0] obs;

  // Channel the rules select for the current inputs, -1 when none requests.
  function automatic int model_grant(input int id);
    int start;
    int c;
    start = (mode[id] == 1) ? 0 : m_ptr[id];
    for (int k = 0; k < n_ch[id]; k++) begin
      c = (start + k) % n_ch[id];
      if (cur_v[id][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_ready(input int id);
    int g;
    g = model_grant(id);
    if (cur_rst[id] || g < 0 || (m_full[id] && !cur_r[id])) return 16'h0;
    return 16'h1 << g;
  endfunction

  function automatic logic [36:0] model_out(input int id);
    return {m_full[id], 4'(m_sel[id]), m_data[id]};
  endfunction

  task automatic model_update(input int id);
    int g;
    g = model_grant(id);
    if (cur_rst[id]) begin
      m_full[id] = 1'b0; m_data[id] = '0; m_sel[id] = 0; m_ptr[id] = 0;
    end else if ((!m_full[id] || cur_r[id]) && g >= 0) begin
      m_full[id] = 1'b1; m_data[id] = ch_data[id][g]; m_sel[id] = g;
      m_ptr[id]  = (g + 1) % n_ch[id];
    end else if (cur_r[id]) begin
      m_full[id] = 1'b0;
    end
  endtask

  task automatic drive(input int id, input logic [15:0] v, input logic r, input logic rv);
    cur_v[id] = v & ((16'h1 << n_ch[id]) - 16'h1);
    cur_r[id] = r;
    cur_rst[id] = rv;
    case (id)
      0: begin
        rst0 = rv; b4.in_valid = v[3:0]; b4.out_ready = r;
        for (int i = 0; i < 4; i++) b4.in_data[i*32 +: 32] = ch_data[0][i];
      end
      1: begin
        rst1 = rv; f4.in_valid = v[3:0]; f4.out_ready = r;
        for (int i = 0; i < 4; i++) f4.in_data[i*32 +: 32] = ch_data[1][i];
      end
      default: begin
        rst2 = rv; b3.in_valid = v[2:0]; b3.out_ready = r;
        for (int i = 0; i < 3; i++) b3.in_data[i*32 +: 32] = ch_data[2][i];
      end
    endcase
  endtask

  task automatic sample(input int id, output logic [15:0] r, output logic [36:0] o);
    case (id)
      0:       begin r = 16'(b4.in_ready); o = {b4.out_valid, 4'(b4.out_sel), b4.out_data}; end
      1:       begin r = 16'(f4.in_ready); o = {f4.out_valid, 4'(f4.out_sel), f4.out_data}; end
      default: begin r = 16'(b3.in_ready); o = {b3.out_valid, 4'(b3.out_sel), b3.out_data}; end
    endcase
  endtask

  // Inputs change on the falling edge; in_ready is sampled 1 time unit later.
  task automatic set_inputs(input int id, input logic [15:0] v, input logic r, input logic rv);
    @(negedge clk);
    drive(id, v, r, rv);
    #1;
  endtask

  // Registered outputs are sampled 1 time unit after the rising edge.
  task automatic clock(input int id);
    @(posedge clk);
    model_update(id);
    #1;
  endtask

  task automatic do_reset(input int id);
    for (int k = 0; k < 2; k++) begin
      set_inputs(id, 16'h0, 1'b0, 1'b1);
      clock(id);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) ch_data[0][i] = 32'h10 + 32'(i);
    for (int k = 0; k < 3; k++) begin
      set_inputs(0, 16'hF, 1'b1, 1'b1);
      sample(0, rdy, obs);
      tests_run++;
      if (rdy !== 16'h0) begin
        tests_failed++;
        $display("FAIL reset_in_ready cyc=%0d got=%h exp=0000", k, rdy);
      end
      clock(0);
      sample(0, rdy, obs);
      tests_run++;
      if (obs[36:32] !== 5'h0) begin
        tests_failed++;
        $display("FAIL reset_out valid/sel cyc=%0d got=%h exp=00", k, obs[36:32]);
      end
    end
    set_inputs(0, 16'hF, 1'b1, 1'b0);
    sample(0, rdy, obs);
    tests_run++;
    if (rdy !== 16'h1) begin
      tests_failed++;
      $display("FAIL reset_first_grant got=%h exp=0001", rdy);
    end
    clock(0);
    sample(0, rdy, obs);
    tests_run++;
    if (obs !== {1'b1, 4'd0, 32'h10}) begin
      tests_failed++;
      $display("FAIL reset_first_out got=%h exp=%h", obs, {1'b1, 4'd0, 32'h10});
    end
  endtask

  task automatic test_round_robin();
    do_reset(0);
    for (int i = 0; i < 4; i++) ch_data[0][i] = 32'hA0 + 32'(i);
    for (int k = 0; k < 8; k++) begin
      set_inputs(0, 16'hF, 1'b1, 1'b0);
      sample(0, rdy, obs);
      tests_run++;
      if (rdy !== (16'h1 << (k % 4))) begin
        tests_failed++;
        $display("FAIL rr_in_ready cyc=%0d got=%h exp=%h", k, rdy, 16'h1 << (k % 4));
      end
      clock(0);
      sample(0, rdy, obs);
      tests_run++;
      if (obs !== {1'b1, 4'(k % 4), 32'hA0 + 32'(k % 4)}) begin
        tests_failed++;
        $display("FAIL rr_out cyc=%0d got=%h exp=%h", k, obs,
                 {1'b1, 4'(k % 4), 32'hA0 + 32'(k % 4)});
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(0);
    for (int i = 0; i < 4; i++) ch_data[0][i] = 32'h100 + 32'(i);
    ch_data[0][2] = 32'hDEADBEEF;
    set_inputs(0, 16'h4, 1'b1, 1'b0);
    clock(0);
    for (int k = 0; k < 5; k++) begin
      set_inputs(0, 16'hF, 1'b0, 1'b0);
      sample(0, rdy, obs);
      tests_run++;
      if (rdy !== 16'h0) begin
        tests_failed++;
        $display("FAIL bp_in_ready cyc=%0d got=%h exp=0000", k, rdy);
      end
      clock(0);
      sample(0, rdy, obs);
      tests_run++;
      if (obs !== {1'b1, 4'd2, 32'hDEADBEEF}) begin
        tests_failed++;
        $display("FAIL bp_hold cyc=%0d got=%h exp=%h", k, obs, {1'b1, 4'd2, 32'hDEADBEEF});
      end
    end
    set_inputs(0, 16'hF, 1'b1, 1'b0);
    sample(0, rdy, obs);
    tests_run++;
    if (rdy !== 16'h8) begin
      tests_failed++;
      $display("FAIL bp_release_ready got=%h exp=0008", rdy);
    end
    clock(0);
    sample(0, rdy, obs);
    tests_run++;
    if (obs !== {1'b1, 4'd3, 32'h103}) begin
      tests_failed++;
      $display("FAIL bp_release_out got=%h exp=%h", obs, {1'b1, 4'd3, 32'h103});
    end
  endtask

  task automatic test_fixed_priority();
    do_reset(1);
    for (int i = 0; i < 4; i++) ch_data[1][i] = 32'hF0 + 32'(i);
    for (int k = 0; k < 5; k++) begin
      set_inputs(1, (k < 4) ? 16'hA : 16'h8, 1'b1, 1'b0);
      sample(1, rdy, obs);
      tests_run++;
      if (rdy !== ((k < 4) ? 16'h2 : 16'h8)) begin
        tests_failed++;
        $display("FAIL fixed_in_ready cyc=%0d got=%h exp=%h", k, rdy, (k < 4) ? 16'h2 : 16'h8);
      end
      clock(1);
      sample(1, rdy, obs);
      tests_run++;
      if (obs !== ((k < 4) ? {1'b1, 4'd1, 32'hF1} : {1'b1, 4'd3, 32'hF3})) begin
        tests_failed++;
        $display("FAIL fixed_out cyc=%0d got=%h", k, obs);
      end
    end
  endtask

  task automatic test_non_pow2();
    do_reset(2);
    for (int i = 0; i < 3; i++) ch_data[2][i] = 32'hC0 + 32'(i);
    set_inputs(2, 16'h4, 1'b1, 1'b0);
    clock(2);
    sample(2, rdy, obs);
    tests_run++;
    if (obs !== {1'b1, 4'd2, 32'hC2}) begin
      tests_failed++;
      $display("FAIL np2_last_ch got=%h exp=%h", obs, {1'b1, 4'd2, 32'hC2});
    end
    for (int k = 0; k < 6; k++) begin
      set_inputs(2, 16'h7, 1'b1, 1'b0);
      sample(2, rdy, obs);
      tests_run++;
      if (rdy !== (16'h1 << (k % 3))) begin
        tests_failed++;
        $display("FAIL np2_in_ready cyc=%0d got=%h exp=%h", k, rdy, 16'h1 << (k % 3));
      end
      clock(2);
      sample(2, rdy, obs);
      tests_run++;
      if (obs !== {1'b1, 4'(k % 3), 32'hC0 + 32'(k % 3)}) begin
        tests_failed++;
        $display("FAIL np2_out cyc=%0d got=%h", k, obs);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    for (int i = 0; i < 4; i++) ch_data[0][i] = 32'h5A5A0000 + 32'(i);
    set_inputs(0, 16'h1, 1'b1, 1'b0);
    clock(0);
    set_inputs(0, 16'h0, 1'b0, 1'b0);
    clock(0);
    sample(0, rdy, obs);
    tests_run++;
    if (obs !== {1'b1, 4'd0, 32'h5A5A0000}) begin
      tests_failed++;
      $display("FAIL mid_full got=%h exp=%h", obs, {1'b1, 4'd0, 32'h5A5A0000});
    end
    set_inputs(0, 16'hF, 1'b1, 1'b1);
    sample(0, rdy, obs);
    tests_run++;
    if (rdy !== 16'h0) begin
      tests_failed++;
      $display("FAIL mid_rst_ready got=%h exp=0000", rdy);
    end
    clock(0);
    for (int k = 0; k < 2; k++) begin
      sample(0, rdy, obs);
      tests_run++;
      if (obs !== 37'h0) begin
        tests_failed++;
        $display("FAIL mid_discard cyc=%0d got=%h exp=0", k, obs);
      end
      set_inputs(0, 16'h0, 1'b1, 1'b0);
      clock(0);
    end
  endtask

  task automatic test_random(input int id);
    logic [15:0] v;
    logic        r, rv;
    do_reset(id);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 16; i++) ch_data[id][i] = $urandom;
      v  = 16'($urandom);
      r  = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 49) == 0);
      set_inputs(id, v, r, rv);
      sample(id, rdy, obs);
      tests_run++;
      if (rdy !== model_ready(id)) begin
        tests_failed++;
        $display("FAIL rand_in_ready id=%0d cyc=%0d got=%h exp=%h", id, k, rdy, model_ready(id));
      end
      clock(id);
      sample(id, rdy, obs);
      tests_run++;
      if (obs !== model_out(id)) begin
        tests_failed++;
        $display("FAIL rand_out id=%0d cyc=%0d got=%h exp=%h", id, k, obs, model_out(id));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int id = 0; id < 3; id++) begin
      for (int i = 0; i < 16; i++) ch_data[id][i] = '0;
      m_full[id] = 1'b0; m_data[id] = '0; m_sel[id] = 0; m_ptr[id] = 0;
      drive(id, 16'h0, 1'b0, 1'b1);
    end
    for (int id = 0; id < 3; id++) do_reset(id);

    test_reset();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_non_pow2();
    test_reset_mid();
    test_random(0);
    test_random(1);
    test_random(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
